// File: rtl/fifo_arbiter_pkg.sv
// Shared definitions for the fifo_arbiter slice: FSM state encoding,
// default sizes and the one-hot to index helper used by the arbiter.
package fifo_arbiter_pkg;

    localparam int DATA_WIDTH_DEF = 6;
    localparam int NUM_FIFOS_DEF  = 4;
    localparam int IDX_W          = $clog2(NUM_FIFOS_DEF);

    typedef enum logic [1:0] {
        ST_INIT   = 2'b00,
        ST_IDLE   = 2'b01,
        ST_ACTIVE = 2'b10,
        ST_PAUSE  = 2'b11
    } state_e;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_FIFOS_DEF-1:0] oh);
        onehot_to_idx = '0;
        for (int i = 0; i < NUM_FIFOS_DEF; i++) begin
            if (oh[i]) onehot_to_idx = IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/fifo_arbiter_rr_selector.sv
// Combinational round-robin pick: the first non-empty FIFO after last_grant,
// wrapping around, with last_grant itself considered last.
module rr_selector
    import fifo_arbiter_pkg::*;
#(
    parameter int NUM_FIFOS = NUM_FIFOS_DEF
) (
    input  logic [NUM_FIFOS-1:0] fifo_empty,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [NUM_FIFOS-1:0] grant,
    output logic                 valid
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_FIFOS; k++) begin
            idx = last_grant + IDX_W'(k);
            if (!valid && !fifo_empty[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_arbiter.sv
// Drains four upstream FIFOs round-robin into one downstream FIFO through a
// two-stage pipeline (FIFO read latency plus an output register).
module fifo_arbiter
    import fifo_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_FIFOS  = NUM_FIFOS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FIFOS-1:0]  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data0,
    input  logic [DATA_WIDTH-1:0] fifo_data1,
    input  logic [DATA_WIDTH-1:0] fifo_data2,
    input  logic [DATA_WIDTH-1:0] fifo_data3,
    output logic [NUM_FIFOS-1:0]  fifo_rd_enable,
    input  logic                  down_almost_full,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  wr_enable,
    output logic [1:0]            state
);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      last_grant_q, last_grant_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
    logic                  wr_enable_q, wr_enable_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    logic [NUM_FIFOS-1:0]  grant;
    logic                  grant_valid;
    logic [IDX_W-1:0]      grant_idx;
    logic                  rd_fire;
    logic [DATA_WIDTH-1:0] sel_data;

    rr_selector #(
        .NUM_FIFOS (NUM_FIFOS)
    ) u_rr_selector (
        .fifo_empty (fifo_empty),
        .last_grant (last_grant_q),
        .grant      (grant),
        .valid      (grant_valid)
    );

    // Read strobe reacts to almost-full in the same cycle, so it stays combinational.
    always_comb begin
        fifo_rd_enable = '0;
        if (state_q == ST_ACTIVE && !down_almost_full && grant_valid) begin
            fifo_rd_enable = grant;
        end
        rd_fire   = |fifo_rd_enable;
        grant_idx = onehot_to_idx(grant);
    end

    always_comb begin
        case (rd_idx_q)
            2'd0:    sel_data = fifo_data0;
            2'd1:    sel_data = fifo_data1;
            2'd2:    sel_data = fifo_data2;
            default: sel_data = fifo_data3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (down_almost_full) begin
            state_d = ST_PAUSE;
        end else if (!(&fifo_empty)) begin
            state_d = ST_ACTIVE;
        end else begin
            state_d = ST_IDLE;
        end

        last_grant_d = rd_fire ? grant_idx : last_grant_q;
        rd_valid_d   = rd_fire;
        rd_idx_d     = rd_fire ? grant_idx : rd_idx_q;
        wr_enable_d  = rd_valid_q;
        data_out_d   = rd_valid_q ? sel_data : data_out_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_INIT;
            last_grant_q <= '1;
            rd_valid_q   <= 1'b0;
            rd_idx_q     <= '0;
            wr_enable_q  <= 1'b0;
            data_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rd_valid_q   <= rd_valid_d;
            rd_idx_q     <= rd_idx_d;
            wr_enable_q  <= wr_enable_d;
            data_out_q   <= data_out_d;
        end
    end

    assign data_out  = data_out_q;
    assign wr_enable = wr_enable_q;
    assign state     = state_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter: four behavioural upstream FIFOs with one-cycle
// read latency, cycle-by-cycle tables of expected strobes, data and state.
module tb_fifo_arbiter;

    logic       clk;
    logic       reset = 1'b1;
    logic [3:0] fifo_empty;
    logic [3:0] fifo_rd_enable;
    logic       down_almost_full = 1'b0;
    logic [5:0] data_out;
    logic       wr_enable;
    logic [1:0] state;

    logic [5:0] mem    [4][64];
    logic [5:0] wr_ptr [4] = '{default: '0};
    logic [5:0] rd_ptr [4] = '{default: '0};
    logic [5:0] fdata  [4] = '{default: '0};

    int vectors     = 0;
    int miscompares = 0;

    fifo_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .fifo_empty       (fifo_empty),
        .fifo_data0       (fdata[0]),
        .fifo_data1       (fdata[1]),
        .fifo_data2       (fdata[2]),
        .fifo_data3       (fdata[3]),
        .fifo_rd_enable   (fifo_rd_enable),
        .down_almost_full (down_almost_full),
        .data_out         (data_out),
        .wr_enable        (wr_enable),
        .state            (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream FIFO model: data_out registered on the read strobe.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (fifo_rd_enable[i]) begin
                fdata[i]  <= mem[i][rd_ptr[i]];
                rd_ptr[i] <= rd_ptr[i] + 6'd1;
            end
        end
    end

    always_comb begin
        fifo_empty = '0;
        for (int i = 0; i < 4; i++) fifo_empty[i] = (rd_ptr[i] == wr_ptr[i]);
    end

    task automatic push(input int f, input logic [5:0] v);
        mem[f][wr_ptr[f]] = v;
        wr_ptr[f] = wr_ptr[f] + 6'd1;
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        down_almost_full = 1'b0;
        reset = 1'b0;
        go();
        reset = 1'b1;
        go();
    endtask

    task automatic test_reset();
        logic [1:0] e_st [3] = '{2'd0, 2'd0, 2'd1};
        #2 reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) reset = 1'b1;
            @(negedge clk);
            vectors += 3;
            if (state !== e_st[c]) begin
                miscompares++;
                $display("FAIL reset.state cyc %0d: got %0d want %0d", c, state, e_st[c]);
            end
            if (fifo_rd_enable !== 4'h0) begin
                miscompares++;
                $display("FAIL reset.rd cyc %0d: got %b want 0000", c, fifo_rd_enable);
            end
            if (wr_enable !== 1'b0 || (c == 0 && data_out !== 6'h00)) begin
                miscompares++;
                $display("FAIL reset.wr cyc %0d: got wr=%b data=%h want wr=0 data=00", c, wr_enable, data_out);
            end
            go();
        end
    endtask

    task automatic test_interleave();
        logic [3:0] e_rd [7] = '{4'h0, 4'h1, 4'h4, 4'h1, 4'h0, 4'h0, 4'h0};
        logic       e_wr [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [5:0] e_d  [7] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h21, 6'h02, 6'h02};
        logic [1:0] e_st [7] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1};
        do_reset();
        push(0, 6'h01); push(0, 6'h02); push(2, 6'h21);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            vectors += 4;
            if (fifo_rd_enable !== e_rd[c]) begin
                miscompares++;
                $display("FAIL interleave.rd cyc %0d: got %b want %b", c, fifo_rd_enable, e_rd[c]);
            end
            if (wr_enable !== e_wr[c]) begin
                miscompares++;
                $display("FAIL interleave.wr cyc %0d: got %b want %b", c, wr_enable, e_wr[c]);
            end
            if (data_out !== e_d[c]) begin
                miscompares++;
                $display("FAIL interleave.data cyc %0d: got %h want %h", c, data_out, e_d[c]);
            end
            if (state !== e_st[c]) begin
                miscompares++;
                $display("FAIL interleave.state cyc %0d: got %0d want %0d", c, state, e_st[c]);
            end
            go();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e_rd [9] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0};
        logic       e_wr [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [5:0] e_d  [9] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h11, 6'h21, 6'h31, 6'h05, 6'h05};
        logic [1:0] e_st [9] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1};
        do_reset();
        push(0, 6'h01); push(0, 6'h05); push(1, 6'h11); push(2, 6'h21); push(3, 6'h31);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            vectors += 4;
            if (fifo_rd_enable !== e_rd[c]) begin
                miscompares++;
                $display("FAIL b2b.rd cyc %0d: got %b want %b", c, fifo_rd_enable, e_rd[c]);
            end
            if (wr_enable !== e_wr[c]) begin
                miscompares++;
                $display("FAIL b2b.wr cyc %0d: got %b want %b", c, wr_enable, e_wr[c]);
            end
            if (data_out !== e_d[c]) begin
                miscompares++;
                $display("FAIL b2b.data cyc %0d: got %h want %h", c, data_out, e_d[c]);
            end
            if (state !== e_st[c]) begin
                miscompares++;
                $display("FAIL b2b.state cyc %0d: got %0d want %0d", c, state, e_st[c]);
            end
            go();
        end
    endtask

    task automatic test_pause();
        logic       e_af [16] = '{0,0,0,1,1,1,0,0,0,0,0,0,0,0,0,0};
        logic [3:0] e_rd [16] = '{4'h0, 4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4,
                                  4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0};
        logic       e_wr [16] = '{0,0,0,1,1,0,0,0,0,1,1,1,1,1,1,0};
        logic [5:0] e_d  [16] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h11, 6'h11, 6'h11, 6'h11,
                                  6'h11, 6'h21, 6'h31, 6'h02, 6'h12, 6'h22, 6'h32, 6'h32};
        logic [1:0] e_st [16] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd2,
                                  2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1};
        do_reset();
        push(0, 6'h01); push(0, 6'h02); push(1, 6'h11); push(1, 6'h12);
        push(2, 6'h21); push(2, 6'h22); push(3, 6'h31); push(3, 6'h32);
        for (int c = 0; c < 16; c++) begin
            down_almost_full = e_af[c];
            @(negedge clk);
            vectors += 4;
            if (fifo_rd_enable !== e_rd[c]) begin
                miscompares++;
                $display("FAIL pause.rd cyc %0d: got %b want %b", c, fifo_rd_enable, e_rd[c]);
            end
            if (wr_enable !== e_wr[c]) begin
                miscompares++;
                $display("FAIL pause.wr cyc %0d: got %b want %b", c, wr_enable, e_wr[c]);
            end
            if (data_out !== e_d[c]) begin
                miscompares++;
                $display("FAIL pause.data cyc %0d: got %h want %h", c, data_out, e_d[c]);
            end
            if (state !== e_st[c]) begin
                miscompares++;
                $display("FAIL pause.state cyc %0d: got %0d want %0d", c, state, e_st[c]);
            end
            go();
        end
        down_almost_full = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic       e_rst [10] = '{1,1,1,0,1,1,1,1,1,1};
        logic [3:0] e_rd  [10] = '{4'h0, 4'h1, 4'h2, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
        logic       e_wr  [10] = '{0,0,0,0,0,0,0,1,1,0};
        logic [5:0] e_d   [10] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h03};
        logic [1:0] e_st  [10] = '{2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1};
        do_reset();
        push(0, 6'h01); push(0, 6'h02); push(0, 6'h03); push(1, 6'h11);
        for (int c = 0; c < 10; c++) begin
            reset = e_rst[c];
            @(negedge clk);
            vectors += 4;
            if (fifo_rd_enable !== e_rd[c]) begin
                miscompares++;
                $display("FAIL rstmid.rd cyc %0d: got %b want %b", c, fifo_rd_enable, e_rd[c]);
            end
            if (wr_enable !== e_wr[c]) begin
                miscompares++;
                $display("FAIL rstmid.wr cyc %0d: got %b want %b", c, wr_enable, e_wr[c]);
            end
            if (data_out !== e_d[c]) begin
                miscompares++;
                $display("FAIL rstmid.data cyc %0d: got %h want %h", c, data_out, e_d[c]);
            end
            if (state !== e_st[c]) begin
                miscompares++;
                $display("FAIL rstmid.state cyc %0d: got %0d want %0d", c, state, e_st[c]);
            end
            go();
        end
        reset = 1'b1;
    endtask

    task automatic test_single();
        logic [3:0] e_rd [8] = '{4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0};
        logic       e_wr [8] = '{0,0,0,1,1,1,1,0};
        logic [5:0] e_d  [8] = '{6'h00, 6'h00, 6'h00, 6'h31, 6'h32, 6'h33, 6'h34, 6'h34};
        logic [1:0] e_st [8] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1};
        do_reset();
        push(3, 6'h31); push(3, 6'h32); push(3, 6'h33); push(3, 6'h34);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            vectors += 4;
            if (fifo_rd_enable !== e_rd[c]) begin
                miscompares++;
                $display("FAIL single.rd cyc %0d: got %b want %b", c, fifo_rd_enable, e_rd[c]);
            end
            if (wr_enable !== e_wr[c]) begin
                miscompares++;
                $display("FAIL single.wr cyc %0d: got %b want %b", c, wr_enable, e_wr[c]);
            end
            if (data_out !== e_d[c]) begin
                miscompares++;
                $display("FAIL single.data cyc %0d: got %h want %h", c, data_out, e_d[c]);
            end
            if (state !== e_st[c]) begin
                miscompares++;
                $display("FAIL single.state cyc %0d: got %0d want %0d", c, state, e_st[c]);
            end
            go();
        end
    endtask

    initial begin
        test_reset();
        test_interleave();
        test_back_to_back();
        test_pause();
        test_reset_mid();
        test_single();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
